rom_load_ctrl: RTL and testbench
================================

# rom_load_ctrl

Sequences the HPS ROM download stream into the game's program ROM and vector ROM. It shares the single ROM write/address port between loader writes and CPU reads, and holds the game core in reset until a complete image has been written. It sits between `hps_io` (ioctl stream) and `ASTEROIDS_TOP`'s ROM blocks, in the `clk_25` domain.

## Interface
Parameters:
- `PROG_BYTES`, default 6144: program ROM size; occupies addresses 0x0000–0x17FF.
- `VEC_BYTES`, default 2048: vector ROM size; occupies addresses 0x1800–0x1FFF.
- `HOLD_CYCLES`, default 256: reset hold time after the load drains.
- `FIFO_DEPTH`, default 4: download byte buffer depth, a power of two.

Ports:
- `clk_25` in 1: the only clock.
- `RESET_L` in 1: asynchronous, active-low reset.
- `dn_download` in 1: download window active.
- `dn_wr` in 1: one-cycle byte strobe.
- `dn_addr` in 16: byte address.
- `dn_data` in 8: byte data.
- `cpu_rd` in 1: CPU read request; held until `cpu_ack`.
- `cpu_addr` in 13: CPU ROM address.
- `cpu_ack` out 1: one-cycle pulse; ROM data is valid in this cycle.
- `rom_addr` out 13: registered ROM address.
- `rom_din` out 8: registered ROM write data.
- `rom_we` out 1: write strobe.
- `rom_sel` out 2: one-hot region select; bit0 is program, bit1 is vector.
- `game_reset_l` out 1: active-low reset to the game core.
- `load_done` out 1: sticky; the last load completed cleanly.
- `load_err` out 1: sticky; the last load overflowed or was short.

## Operation
- States are IDLE, LOAD, DRAIN, HOLD and RUN. Reset enters IDLE.
- Reset values: `game_reset_l`=0, `rom_we`=0, `rom_sel`=0, `rom_addr`=0, `rom_din`=0, `cpu_ack`=0, `load_done`=0, `load_err`=0. The FIFO and byte counter are cleared.
- IDLE→LOAD on the rising edge of `dn_download`. RUN→LOAD and HOLD→LOAD also occur on that edge, which restarts the load. Entering LOAD clears the counter, `load_done` and `load_err`.
- LOAD→DRAIN when `dn_download` falls.
- DRAIN→HOLD when the FIFO is empty.
- In HOLD, a counter runs for HOLD_CYCLES clocks. When it expires:
  - if the count equals PROG_BYTES+VEC_BYTES and no overflow occurred, go to RUN and set `load_done`;
  - otherwise go to IDLE and set `load_err`.
- `game_reset_l`=1 only in RUN.
- Decode:
  - `dn_addr` < PROG_BYTES: region 0.
  - `dn_addr` < PROG_BYTES+VEC_BYTES: region 1.
  - Otherwise the byte is discarded: it is not queued and not counted.
- `dn_wr` is honoured only in LOAD. Each accepted byte pushes {addr[12:0], data, region} into the FIFO and increments the 14-bit counter, which saturates.
- A push while the FIFO is full drops the byte and flags overflow.
- Arbitration is evaluated each cycle:
  - if the FIFO is non-empty, pop it and register a write (`rom_we`=1, `rom_sel`=one-hot region);
  - else if `cpu_rd` is high, register `rom_addr`=`cpu_addr`, `rom_we`=0, `rom_sel`=0, and pulse `cpu_ack` on the next cycle;
  - else `rom_we`=0.
  - Writes always win. A pending CPU read waits without losing its request.
- CPU reads are served in any state.
- After an ack, the same `cpu_rd` level must be re-arbitrated. The CPU deasserts `cpu_rd` in the ack cycle, or it starts a new read.
- Removing `RESET_L` mid-load forces IDLE immediately and discards the FIFO contents.

## Timing
- `dn_wr` sampled at edge N with an empty FIFO: the FIFO is written at N and `rom_we` is high in the cycle after edge N+1. The latency is 2 clocks.
- Sustained throughput is 1 byte/clock, so the FIFO never fills at the ioctl rate. Overflow is reachable only in test.
- CPU read granted at edge M: `rom_addr` is valid after M and `cpu_ack` is high after M+1, which matches a 1-cycle synchronous ROM.
- A simultaneous `dn_wr` push and pop when the FIFO is full is accepted, because the pop frees the slot in the same cycle.
- `game_reset_l` rises exactly HOLD_CYCLES clocks after the FIFO empties in DRAIN.

## Structure
- Shared package `rom_load_pkg`: the state enum, region encoding (`REG_PROG`=0, `REG_VEC`=1), and the default sizes.
- One sub-module, `rom_load_fifo`: a synchronous FIFO with full/empty flags and same-cycle push/pop when full.
- The FSM, decode, counter and arbiter live in the top level.

## Test plan
- Full load: 8192 sequential bytes at 1/clock, then `dn_download` falls.
  - Expect 6144 writes with `rom_sel`=01 and 2048 writes with `rom_sel`=10, addresses 0x0000–0x1FFF.
  - `game_reset_l` rises 256 clocks after drain; `load_done`=1.
- Short load: 8000 bytes. Expect `load_err`=1, `game_reset_l` stays 0, and the state returns to IDLE.
- Out-of-range: bytes at 0x2000–0x20FF interleaved with a full load. Expect no extra `rom_we`, and `load_done`=1.
- Contention: hold `cpu_rd` with `cpu_addr`=0x1234 during a 4-byte burst. Expect 4 writes first, then `cpu_ack` 2 clocks after the last pop with `rom_addr`=0x1234.
- Overflow: force FIFO_DEPTH=2 and stall pops via a test hook. Expect a dropped byte and `load_err`=1.
- Async reset: drop `RESET_L` mid-load at byte 3000. Expect all outputs at reset values the same cycle and no `rom_we` afterwards.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and default sizes for the ROM download controller.
package rom_load_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_e;

  typedef enum logic {
    REG_PROG = 1'b0,
    REG_VEC  = 1'b1
  } region_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
    region_e     region;
  } fifo_ent_t;

  localparam int DEF_PROG_BYTES  = 6144;
  localparam int DEF_VEC_BYTES   = 2048;
  localparam int DEF_HOLD_CYCLES = 256;
  localparam int DEF_FIFO_DEPTH  = 4;

  function automatic logic [1:0] region_sel(input region_e r);
    return (r == REG_VEC) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rom_load_fifo.sv
// Synchronous FIFO, combinational head read; a push into a full FIFO is taken
// only when a pop frees the slot in the same cycle, otherwise it is dropped.
module rom_load_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Streams ioctl download bytes into program/vector ROM through a small FIFO, sharing the ROM port
// with CPU reads (writes win; byte-to-rom_we 2 clocks, read ack 2 clocks); holds the game in reset until loaded.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int PROG_BYTES  = DEF_PROG_BYTES,
  parameter int VEC_BYTES   = DEF_VEC_BYTES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clk_25,
  input  logic        RESET_L,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        cpu_rd,
  input  logic [12:0] cpu_addr,
  input  logic        test_stall,
  output logic        cpu_ack,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_din,
  output logic        rom_we,
  output logic [1:0]  rom_sel,
  output logic        game_reset_l,
  output logic        load_done,
  output logic        load_err
);

  state_e      state;
  logic        dl_q;
  logic        dl_rise;
  logic [13:0] cnt;
  logic        ovf;
  logic [15:0] hold_cnt;
  logic        ack_pend;
  logic        in_prog;
  logic        in_vec;
  logic        accept;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_ent_t   push_ent;
  fifo_ent_t   head;

  assign dl_rise  = dn_download && !dl_q;
  assign in_prog  = (dn_addr < 16'(PROG_BYTES));
  assign in_vec   = !in_prog && (dn_addr < 16'(PROG_BYTES + VEC_BYTES));
  assign accept   = (state == LOAD) && dn_wr && (in_prog || in_vec);
  // test_stall freezes the pop side so overflow can be provoked; tie low in the system.
  assign fifo_pop = !fifo_empty && !test_stall;

  always_comb begin
    push_ent        = '0;
    push_ent.addr   = dn_addr[12:0];
    push_ent.data   = dn_data;
    push_ent.region = in_prog ? REG_PROG : REG_VEC;
  end

  rom_load_fifo #(
    .WIDTH($bits(fifo_ent_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_25),
    .rst_n (RESET_L),
    .push  (accept),
    .wdata (push_ent),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state        <= IDLE;
      dl_q         <= 1'b0;
      cnt          <= '0;
      ovf          <= 1'b0;
      hold_cnt     <= '0;
      game_reset_l <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      dl_q <= dn_download;
      if (accept) begin
        if (fifo_full && !fifo_pop) ovf <= 1'b1;
        if (cnt != '1) cnt <= cnt + 14'd1;
      end
      if (dl_rise && (state inside {IDLE, HOLD, RUN})) begin
        state        <= LOAD;
        cnt          <= '0;
        ovf          <= 1'b0;
        load_done    <= 1'b0;
        load_err     <= 1'b0;
        game_reset_l <= 1'b0;
      end else begin
        case (state)
          LOAD:  if (!dn_download) state <= DRAIN;
          DRAIN: if (fifo_empty) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
          HOLD: begin
            if (hold_cnt == 16'(HOLD_CYCLES - 1)) begin
              if ((cnt == 14'(PROG_BYTES + VEC_BYTES)) && !ovf) begin
                state        <= RUN;
                load_done    <= 1'b1;
                game_reset_l <= 1'b1;
              end else begin
                state    <= IDLE;
                load_err <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ack_pend blocks re-granting the same request while its ack is still in flight.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      rom_we   <= 1'b0;
      rom_sel  <= 2'b00;
      rom_addr <= '0;
      rom_din  <= '0;
      cpu_ack  <= 1'b0;
      ack_pend <= 1'b0;
    end else begin
      cpu_ack  <= ack_pend;
      ack_pend <= 1'b0;
      if (fifo_pop) begin
        rom_we   <= 1'b1;
        rom_sel  <= region_sel(head.region);
        rom_addr <= head.addr;
        rom_din  <= head.data;
      end else if (cpu_rd && !ack_pend) begin
        rom_we   <= 1'b0;
        rom_sel  <= 2'b00;
        rom_addr <= cpu_addr;
        ack_pend <= 1'b1;
      end else begin
        rom_we  <= 1'b0;
        rom_sel <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: default instance plus a FIFO_DEPTH=2 instance for overflow.
module tb_rom_load_ctrl;

  logic        clk_25 = 1'b0;
  logic        RESET_L;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        cpu_rd;
  logic [12:0] cpu_addr;
  logic        stall_b;

  logic        cpu_ack, rom_we, game_reset_l, load_done, load_err;
  logic [12:0] rom_addr;
  logic [7:0]  rom_din;
  logic [1:0]  rom_sel;
  logic        cpu_ack_b, rom_we_b, game_reset_l_b, load_done_b, load_err_b;
  logic [12:0] rom_addr_b;
  logic [7:0]  rom_din_b;
  logic [1:0]  rom_sel_b;

  always #5 clk_25 = ~clk_25;

  rom_load_ctrl dut (
    .clk_25(clk_25), .RESET_L(RESET_L), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .test_stall(1'b0), .cpu_ack(cpu_ack), .rom_addr(rom_addr), .rom_din(rom_din),
    .rom_we(rom_we), .rom_sel(rom_sel), .game_reset_l(game_reset_l),
    .load_done(load_done), .load_err(load_err)
  );

  rom_load_ctrl #(.FIFO_DEPTH(2)) dut_b (
    .clk_25(clk_25), .RESET_L(RESET_L), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .test_stall(stall_b), .cpu_ack(cpu_ack_b), .rom_addr(rom_addr_b), .rom_din(rom_din_b),
    .rom_we(rom_we_b), .rom_sel(rom_sel_b), .game_reset_l(game_reset_l_b),
    .load_done(load_done_b), .load_err(load_err_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_we, n_prog, n_vec, seq_err, n_we_b, seq_err_b;
  int last_we_cyc, rise_cyc, ack_cyc, n_ack, n_ack_b, we_at_ack;
  logic [12:0] exp_wa;
  logic [12:0] ack_addr;
  logic grl_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
  endfunction

  function automatic logic [1:0] exp_sel(input logic [12:0] a);
    return (a < 13'd6144) ? 2'b01 : 2'b10;
  endfunction

  task automatic clr_stats();
    n_we = 0; n_prog = 0; n_vec = 0; seq_err = 0; n_we_b = 0; seq_err_b = 0;
    last_we_cyc = -1; rise_cyc = -1; ack_cyc = -1; n_ack = 0; n_ack_b = 0; we_at_ack = -1;
    exp_wa = '0; ack_addr = '0;
  endtask

  // One clock; outputs are sampled on the falling edge, inputs change there too.
  task automatic tick();
    @(posedge clk_25);
    cyc++;
    @(negedge clk_25);
    if (rom_we) begin
      n_we++;
      last_we_cyc = cyc;
      if (rom_sel == 2'b01) n_prog++;
      else if (rom_sel == 2'b10) n_vec++;
      if (rom_addr !== exp_wa || rom_din !== pat(int'(exp_wa)) || rom_sel !== exp_sel(exp_wa))
        seq_err++;
      exp_wa = exp_wa + 13'd1;
    end
    if (rom_we_b) begin
      if (rom_addr_b !== 13'(n_we_b) || rom_din_b !== pat(n_we_b) || rom_sel_b !== 2'b01)
        seq_err_b++;
      n_we_b++;
    end
    if (cpu_ack) begin
      n_ack++;
      ack_cyc = cyc;
      ack_addr = rom_addr;
      we_at_ack = n_we;
      cpu_rd = 1'b0;
    end
    if (cpu_ack_b) n_ack_b++;
    if (game_reset_l && !grl_prev) rise_cyc = cyc;
    grl_prev = game_reset_l;
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    dn_wr = 1'b1;
    dn_addr = 16'(a);
    dn_data = d;
    tick();
  endtask

  task automatic start_load();
    dn_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_load();
    logic fin;
    fin = 1'b0;
    dn_wr = 1'b0;
    dn_download = 1'b0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      tick();
      fin = (load_done || load_err) && (load_done_b || load_err_b);
    end
    chk("load_end_reached", 32'(fin), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_L = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    cpu_rd = 1'b0; cpu_addr = '0; stall_b = 1'b0;
    clr_stats();
    repeat (3) tick();
    chk("rst_game_reset_l", 32'(game_reset_l), 0);
    chk("rst_rom_we", 32'(rom_we), 0);
    chk("rst_rom_sel", 32'(rom_sel), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_din", 32'(rom_din), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_load_err", 32'(load_err), 0);
    RESET_L = 1'b1;
    repeat (2) tick();

    // Full load
    clr_stats();
    start_load();
    for (int i = 0; i < 8192; i++) wr_byte(i, pat(i));
    end_load();
    chk("full_prog_writes", 32'(n_prog), 6144);
    chk("full_vec_writes", 32'(n_vec), 2048);
    chk("full_seq_err", 32'(seq_err), 0);
    chk("full_load_done", 32'(load_done), 1);
    chk("full_load_err", 32'(load_err), 0);
    chk("full_game_reset_l", 32'(game_reset_l), 1);
    // Last pop empties the FIFO; DRAIN sees it one clock later, then HOLD runs 256 clocks.
    chk("full_hold_delay", 32'(rise_cyc - last_we_cyc), 257);

    // Short load, restarted from RUN
    clr_stats();
    start_load();
    chk("short_restart_reset_l", 32'(game_reset_l), 0);
    chk("short_restart_done_clr", 32'(load_done), 0);
    for (int i = 0; i < 8000; i++) wr_byte(i, pat(i));
    end_load();
    chk("short_writes", 32'(n_we), 8000);
    chk("short_load_err", 32'(load_err), 1);
    chk("short_load_done", 32'(load_done), 0);
    repeat (50) tick();
    chk("short_game_reset_l", 32'(game_reset_l), 0);
    chk("short_err_sticky", 32'(load_err), 1);

    // Out-of-range bytes interleaved with a full load
    clr_stats();
    start_load();
    for (int i = 0; i < 8192; i++) begin
      wr_byte(i, pat(i));
      if (i % 32 == 31) wr_byte(16'h2000 + i / 32, 8'hEE);
    end
    end_load();
    chk("oor_writes", 32'(n_we), 8192);
    chk("oor_seq_err", 32'(seq_err), 0);
    chk("oor_load_done", 32'(load_done), 1);
    chk("oor_load_err", 32'(load_err), 0);

    // CPU read held during a 4-byte burst
    clr_stats();
    start_load();
    cpu_addr = 13'h1234;
    wr_byte(0, pat(0));
    cpu_rd = 1'b1;
    for (int i = 1; i < 4; i++) wr_byte(i, pat(i));
    dn_wr = 1'b0;
    repeat (10) tick();
    chk("cont_ack_count", 32'(n_ack), 1);
    chk("cont_writes_before_ack", 32'(we_at_ack), 4);
    chk("cont_ack_after_pop", 32'(ack_cyc - last_we_cyc), 2);
    chk("cont_ack_addr", 32'(ack_addr), 32'h1234);
    chk("cont_seq_err", 32'(seq_err), 0);
    chk("cont_ack_count_b", 32'(n_ack_b), 1);
    end_load();
    chk("cont_load_err", 32'(load_err), 1);

    // Overflow on the depth-2 instance with pops stalled
    clr_stats();
    start_load();
    stall_b = 1'b1;
    for (int i = 0; i < 3; i++) wr_byte(i, pat(i));
    dn_wr = 1'b0;
    repeat (2) tick();
    chk("ovf_stalled_writes", 32'(n_we_b), 0);
    stall_b = 1'b0;
    end_load();
    chk("ovf_writes_b", 32'(n_we_b), 2);
    chk("ovf_seq_err_b", 32'(seq_err_b), 0);
    chk("ovf_load_err_b", 32'(load_err_b), 1);
    chk("ovf_load_done_b", 32'(load_done_b), 0);
    chk("ovf_game_reset_l_b", 32'(game_reset_l_b), 0);
    chk("ovf_writes_a", 32'(n_we), 3);

    // Asynchronous reset at byte 3000
    clr_stats();
    start_load();
    for (int i = 0; i < 3000; i++) wr_byte(i, pat(i));
    chk("arst_writes_before", 32'(n_we), 2999);
    dn_wr = 1'b1; dn_addr = 16'd3000; dn_data = pat(3000);
    #2 RESET_L = 1'b0;
    #1;
    chk("arst_game_reset_l", 32'(game_reset_l), 0);
    chk("arst_rom_we", 32'(rom_we), 0);
    chk("arst_rom_sel", 32'(rom_sel), 0);
    chk("arst_rom_addr", 32'(rom_addr), 0);
    chk("arst_rom_din", 32'(rom_din), 0);
    chk("arst_cpu_ack", 32'(cpu_ack), 0);
    chk("arst_load_done", 32'(load_done), 0);
    chk("arst_load_err", 32'(load_err), 0);
    n_we = 0;
    for (int i = 3001; i < 3011; i++) wr_byte(i, pat(i));
    dn_wr = 1'b0;
    dn_download = 1'b0;
    tick();
    RESET_L = 1'b1;
    repeat (20) tick();
    chk("arst_no_writes_after", 32'(n_we), 0);
    chk("arst_game_reset_l_after", 32'(game_reset_l), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
